prs_ber_checker: RTL and testbench
==================================

Name: prs_ber_checker

Overview:
- Serial PRS bit-error-rate checker at the decoder output (after o_dec_sym/o_vld).
- Self-synchronises a local PRS generator to the incoming hard-decision stream, then counts bit errors.
- Reports per-window error counts, saturating totals and lock status. Replaces file dumping for on-chip/in-bench BER.
- Generalises the PRS generator: runtime window length, loss threshold, optional inversion.

Parameters:
PRS_LEN, 15, PRS shift-register length (polynomial x^PRS_LEN + x^PRS_TAP + 1)
PRS_TAP, 14, second feedback tap position (1..PRS_LEN-1)
LOCK_CNT, 64, consecutive correct predictions required to declare lock
WIN_W, 24, width of window length and window error count
TOT_W, 32, width of total bit and total error counters

Ports:
clk  in  1  clock
nRESET  in  1  synchronous active-low reset
i_vld  in  1  input bit valid
i_sym  in  1  decoded hard bit
i_invert  in  1  XOR applied to i_sym before checking
i_window_len  in  WIN_W  bits per measurement window; 0 = windows disabled
i_loss_thr  in  WIN_W  window errors above this value drop lock
i_clear  in  1  synchronous clear of the total counters
o_locked  out  1  checker is in LOCKED
o_win_vld  out  1  one-cycle pulse: window result valid
o_win_err  out  WIN_W  errors in the last completed window
o_bit_total  out  TOT_W  checked bits while locked, saturating
o_err_total  out  TOT_W  errors while locked, saturating

Behaviour:
- Reset (nRESET=0 at posedge): state SEARCH; sr, counters and all outputs 0. Reset mid-window aborts the window with no o_win_vld pulse.
- Input bit b = i_sym ^ i_invert. Only cycles with i_vld=1 advance anything.
- Prediction p = sr[PRS_LEN-1] ^ sr[PRS_TAP-1]. The shift is sr <= {sr[PRS_LEN-2:0], x}.
- SEARCH:
  - Shift in x=b and count loaded bits.
  - After PRS_LEN valid bits, go to VERIFY with match counter 0.
  - If sr (including the new bit) is all-zero, restart the load count and stay in SEARCH. This is the lock-up guard.
- VERIFY:
  - Shift in x=b. If b==p, increment the match count; otherwise return to SEARCH with load count 0.
  - When the match count reaches LOCK_CNT, go to LOCKED. o_locked rises in the following cycle.
  - Window counter cleared on entry.
- LOCKED:
  - Shift in x=p; the generator free-runs and is no longer fed by the input.
  - err = (b != p). o_bit_total increments; o_err_total increments when err=1. Both saturate at all-ones.
  - Window counter increments on each bit; the window error count accumulates err, saturating at all-ones.
- Window end, when i_window_len != 0 and this is the i_window_len-th bit of the window:
  - Next cycle: o_win_vld=1 for exactly one cycle, and o_win_err = the window count including this bit.
  - Window counters restart at 0.
  - If o_win_err > i_loss_thr: go to SEARCH (o_locked falls the same cycle o_win_vld is high), sr kept, load count 0.
- i_window_len==0: no pulses, no loss check, lock held indefinitely.
- o_win_err holds its value until the next window ends.
- Changing i_window_len mid-window takes effect immediately. If the current count is already >= the new length, the window ends on the next valid bit.
- i_clear=1 zeroes o_bit_total/o_err_total at the next edge and has priority over an increment in the same cycle. It does not affect state, sr or window counters.
- Latency from a bit in LOCKED to the total counters: 1 cycle.

Test Plan:
1. Error-free PRS (x^15+x^14+1, seed 1), i_vld every cycle, window 1000, thr 10 -> o_locked high after 15+64 bits + 1 cycle; every o_win_err=0; o_err_total=0.
2. Same stream with 1 flipped bit per 100 after lock -> each o_win_err=10; lock held (10 not > 10); o_err_total = 10×windows.
3. Thr 5 with 10 errors per window -> o_locked falls with the first o_win_vld; relock occurs after ≥79 clean bits.
4. All-zero input for 500 bits -> o_locked stays 0; state never leaves SEARCH.
5. Inverted stream with i_invert=1 -> locks and reports 0 errors. With i_invert=0, never locks.
6. i_vld duty 1/64 with i_clear and i_clear pulsed mid-run -> totals return to 0 next cycle and then resume counting; lock and window unaffected. nRESET mid-window -> no o_win_vld pulse; all outputs 0.

Source files
------------

// File: rtl/prs_ber_checker.sv
// Serial PRS bit-error-rate checker: self-synchronises a local x^PRS_LEN + x^PRS_TAP + 1
// generator to the incoming hard-decision stream, then counts windowed and total bit errors.
module prs_ber_checker #(
  parameter int PRS_LEN  = 15,
  parameter int PRS_TAP  = 14,
  parameter int LOCK_CNT = 64,
  parameter int WIN_W    = 24,
  parameter int TOT_W    = 32
) (
  input  logic             clk,
  input  logic             nRESET,
  input  logic             i_vld,
  input  logic             i_sym,
  input  logic             i_invert,
  input  logic [WIN_W-1:0] i_window_len,
  input  logic [WIN_W-1:0] i_loss_thr,
  input  logic             i_clear,
  output logic             o_locked,
  output logic             o_win_vld,
  output logic [WIN_W-1:0] o_win_err,
  output logic [TOT_W-1:0] o_bit_total,
  output logic [TOT_W-1:0] o_err_total
);

  // state  | meaning
  // SEARCH | loading PRS_LEN input bits into the generator
  // VERIFY | generator seeded from input, counting consecutive correct predictions
  // LOCKED | generator free-runs, input compared against it for errors
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam int LD_W = $clog2(PRS_LEN + 1);
  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam logic [LD_W-1:0] LD_LAST = LD_W'(PRS_LEN - 1);
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(LOCK_CNT - 1);

  state_t             state, state_nxt;
  logic [PRS_LEN-1:0] sr, sr_nxt;
  logic [LD_W-1:0]    ld_cnt, ld_cnt_nxt;
  logic [MC_W-1:0]    mc_cnt, mc_cnt_nxt;
  logic [WIN_W-1:0]   win_cnt, win_cnt_nxt;
  logic [WIN_W-1:0]   win_acc, win_acc_nxt;
  logic [WIN_W-1:0]   win_inc, acc_inc;
  logic [WIN_W-1:0]   win_err_nxt;
  logic               win_vld_nxt;
  logic [TOT_W-1:0]   bit_tot_nxt, err_tot_nxt;
  logic               b, p, err;

  assign b        = i_sym ^ i_invert;
  assign p        = sr[PRS_LEN-1] ^ sr[PRS_TAP-1];
  assign o_locked = (state == LOCKED);

  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    ld_cnt_nxt  = ld_cnt;
    mc_cnt_nxt  = mc_cnt;
    win_cnt_nxt = win_cnt;
    win_acc_nxt = win_acc;
    win_inc     = win_cnt;
    acc_inc     = win_acc;
    win_vld_nxt = 1'b0;
    win_err_nxt = o_win_err;
    bit_tot_nxt = o_bit_total;
    err_tot_nxt = o_err_total;
    err         = 1'b0;

    if (i_vld) begin
      case (state)
        SEARCH: begin
          sr_nxt      = {sr[PRS_LEN-2:0], b};
          win_cnt_nxt = '0;
          win_acc_nxt = '0;
          if (ld_cnt == LD_LAST) begin
            ld_cnt_nxt = '0;
            // an all-zero register would lock onto the degenerate zero sequence
            if (sr_nxt != '0) begin
              state_nxt  = VERIFY;
              mc_cnt_nxt = '0;
            end
          end else begin
            ld_cnt_nxt = ld_cnt + LD_W'(1);
          end
        end

        VERIFY: begin
          sr_nxt      = {sr[PRS_LEN-2:0], b};
          win_cnt_nxt = '0;
          win_acc_nxt = '0;
          if (b == p) begin
            if (mc_cnt == MC_LAST) begin
              state_nxt  = LOCKED;
              mc_cnt_nxt = '0;
            end else begin
              mc_cnt_nxt = mc_cnt + MC_W'(1);
            end
          end else begin
            state_nxt  = SEARCH;
            ld_cnt_nxt = '0;
          end
        end

        LOCKED: begin
          sr_nxt      = {sr[PRS_LEN-2:0], p};
          err         = b ^ p;
          bit_tot_nxt = (&o_bit_total) ? o_bit_total : o_bit_total + TOT_W'(1);
          if (err && !(&o_err_total)) err_tot_nxt = o_err_total + TOT_W'(1);
          win_inc     = (&win_cnt) ? win_cnt : win_cnt + WIN_W'(1);
          acc_inc     = (err && !(&win_acc)) ? win_acc + WIN_W'(1) : win_acc;
          win_cnt_nxt = win_inc;
          win_acc_nxt = acc_inc;
          // >= so that shrinking the window below the current count ends it on this bit
          if ((i_window_len != '0) && (win_inc >= i_window_len)) begin
            win_vld_nxt = 1'b1;
            win_err_nxt = acc_inc;
            win_cnt_nxt = '0;
            win_acc_nxt = '0;
            if (acc_inc > i_loss_thr) begin
              state_nxt  = SEARCH;
              ld_cnt_nxt = '0;
            end
          end
        end

        default: state_nxt = SEARCH;
      endcase
    end

    if (i_clear) begin
      bit_tot_nxt = '0;
      err_tot_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      state       <= SEARCH;
      sr          <= '0;
      ld_cnt      <= '0;
      mc_cnt      <= '0;
      win_cnt     <= '0;
      win_acc     <= '0;
      o_win_vld   <= 1'b0;
      o_win_err   <= '0;
      o_bit_total <= '0;
      o_err_total <= '0;
    end else begin
      state       <= state_nxt;
      sr          <= sr_nxt;
      ld_cnt      <= ld_cnt_nxt;
      mc_cnt      <= mc_cnt_nxt;
      win_cnt     <= win_cnt_nxt;
      win_acc     <= win_acc_nxt;
      o_win_vld   <= win_vld_nxt;
      o_win_err   <= win_err_nxt;
      o_bit_total <= bit_tot_nxt;
      o_err_total <= err_tot_nxt;
    end
  end

endmodule

// File: tb/tb_prs_ber_checker.sv
// Directed bench for prs_ber_checker: lock acquisition, windowed errors, loss of lock,
// lock-up guard, inversion, sparse valid with clears, and reset mid-window.
module tb_prs_ber_checker;
  localparam int WIN_W = 24;
  localparam int TOT_W = 32;

  logic             clk = 1'b0;
  logic             nRESET = 1'b0;
  logic             i_vld = 1'b0;
  logic             i_sym = 1'b0;
  logic             i_invert = 1'b0;
  logic             i_clear = 1'b0;
  logic [WIN_W-1:0] i_window_len = '0;
  logic [WIN_W-1:0] i_loss_thr = '0;
  logic             o_locked;
  logic             o_win_vld;
  logic [WIN_W-1:0] o_win_err;
  logic [TOT_W-1:0] o_bit_total;
  logic [TOT_W-1:0] o_err_total;

  int checks = 0;
  int errors = 0;
  logic [14:0] g;

  always #5 clk = ~clk;

  prs_ber_checker dut (
    .clk(clk), .nRESET(nRESET), .i_vld(i_vld), .i_sym(i_sym), .i_invert(i_invert),
    .i_window_len(i_window_len), .i_loss_thr(i_loss_thr), .i_clear(i_clear),
    .o_locked(o_locked), .o_win_vld(o_win_vld), .o_win_err(o_win_err),
    .o_bit_total(o_bit_total), .o_err_total(o_err_total)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s);
    i_vld = v;
    i_sym = s;
    tick();
    i_vld = 1'b0;
  endtask

  // reference x^15 + x^14 + 1 generator, output = bit shifted in
  task automatic prs_bit(output logic bo);
    bo = g[14] ^ g[13];
    g  = {g[13:0], bo};
  endtask

  task automatic do_reset();
    nRESET = 1'b0;
    i_vld = 1'b0;
    i_clear = 1'b0;
    tick();
    tick();
    nRESET = 1'b1;
  endtask

  task automatic lock_up(input logic inv);
    logic bb;
    g = 15'h0001;
    for (int i = 0; i < 79; i++) begin
      prs_bit(bb);
      drive(1'b1, bb ^ inv);
    end
    checks++;
    if (o_locked !== 1'b1) begin
      errors++; $display("FAIL lock_up got %b exp 1", o_locked);
    end
  endtask

  task automatic test_reset();
    nRESET = 1'b0;
    i_vld = 1'b1;
    i_sym = 1'b1;
    tick();
    tick();
    i_vld = 1'b0;
    checks += 5;
    if (o_locked !== 1'b0)    begin errors++; $display("FAIL rst_locked got %b exp 0", o_locked); end
    if (o_win_vld !== 1'b0)   begin errors++; $display("FAIL rst_win_vld got %b exp 0", o_win_vld); end
    if (o_win_err !== '0)     begin errors++; $display("FAIL rst_win_err got %0d exp 0", o_win_err); end
    if (o_bit_total !== '0)   begin errors++; $display("FAIL rst_bit_total got %0d exp 0", o_bit_total); end
    if (o_err_total !== '0)   begin errors++; $display("FAIL rst_err_total got %0d exp 0", o_err_total); end
    nRESET = 1'b1;
  endtask

  task automatic test_lock_clean();
    logic bb;
    logic ev;
    i_window_len = 24'd1000;
    i_loss_thr   = 24'd10;
    g = 15'h0001;
    for (int i = 1; i <= 79; i++) begin
      prs_bit(bb);
      drive(1'b1, bb);
      if (i == 78) begin
        checks++;
        if (o_locked !== 1'b0) begin errors++; $display("FAIL early_lock got %b exp 0", o_locked); end
      end
    end
    checks++;
    if (o_locked !== 1'b1) begin errors++; $display("FAIL lock_79 got %b exp 1", o_locked); end
    for (int k = 1; k <= 2000; k++) begin
      prs_bit(bb);
      drive(1'b1, bb);
      ev = (k % 1000 == 0);
      checks++;
      if (o_win_vld !== ev) begin errors++; $display("FAIL clean_win_vld k=%0d got %b exp %b", k, o_win_vld, ev); end
      if (ev) begin
        checks++;
        if (o_win_err !== '0) begin errors++; $display("FAIL clean_win_err got %0d exp 0", o_win_err); end
      end
    end
    checks += 3;
    if (o_err_total !== 32'd0)    begin errors++; $display("FAIL clean_err_total got %0d exp 0", o_err_total); end
    if (o_bit_total !== 32'd2000) begin errors++; $display("FAIL clean_bit_total got %0d exp 2000", o_bit_total); end
    if (o_locked !== 1'b1)        begin errors++; $display("FAIL clean_locked got %b exp 1", o_locked); end
  endtask

  task automatic test_errors();
    logic bb;
    logic ev;
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    checks += 2;
    if (o_bit_total !== '0) begin errors++; $display("FAIL clr_bit_total got %0d exp 0", o_bit_total); end
    if (o_err_total !== '0) begin errors++; $display("FAIL clr_err_total got %0d exp 0", o_err_total); end
    for (int k = 0; k < 2000; k++) begin
      prs_bit(bb);
      drive(1'b1, bb ^ (k % 100 == 99));
      ev = ((k + 1) % 1000 == 0);
      checks++;
      if (o_win_vld !== ev) begin errors++; $display("FAIL err_win_vld k=%0d got %b exp %b", k, o_win_vld, ev); end
      if (ev) begin
        checks += 2;
        if (o_win_err !== 24'd10) begin errors++; $display("FAIL err_win_err got %0d exp 10", o_win_err); end
        if (o_locked !== 1'b1)    begin errors++; $display("FAIL err_locked got %b exp 1", o_locked); end
      end
    end
    checks += 2;
    if (o_err_total !== 32'd20)   begin errors++; $display("FAIL err_err_total got %0d exp 20", o_err_total); end
    if (o_bit_total !== 32'd2000) begin errors++; $display("FAIL err_bit_total got %0d exp 2000", o_bit_total); end
  endtask

  task automatic test_win_shrink();
    logic bb;
    for (int k = 0; k < 50; k++) begin
      prs_bit(bb);
      drive(1'b1, bb);
    end
    checks++;
    if (o_win_vld !== 1'b0) begin errors++; $display("FAIL shrink_pre got %b exp 0", o_win_vld); end
    i_window_len = 24'd20;
    prs_bit(bb);
    drive(1'b1, bb);
    checks += 2;
    if (o_win_vld !== 1'b1) begin errors++; $display("FAIL shrink_end got %b exp 1", o_win_vld); end
    if (o_win_err !== '0)   begin errors++; $display("FAIL shrink_err got %0d exp 0", o_win_err); end
    for (int k = 1; k <= 20; k++) begin
      prs_bit(bb);
      drive(1'b1, bb);
      checks++;
      if (o_win_vld !== (k == 20)) begin errors++; $display("FAIL shrink_win k=%0d got %b exp %b", k, o_win_vld, k == 20); end
    end
    i_window_len = 24'd1000;
  endtask

  task automatic test_loss();
    logic bb;
    int n;
    i_loss_thr = 24'd5;
    for (int k = 0; k < 1000; k++) begin
      prs_bit(bb);
      drive(1'b1, bb ^ (k % 100 == 99));
      if (k == 998) begin
        checks++;
        if (o_locked !== 1'b1) begin errors++; $display("FAIL loss_pre got %b exp 1", o_locked); end
      end
    end
    checks += 3;
    if (o_win_vld !== 1'b1)   begin errors++; $display("FAIL loss_win_vld got %b exp 1", o_win_vld); end
    if (o_win_err !== 24'd10) begin errors++; $display("FAIL loss_win_err got %0d exp 10", o_win_err); end
    if (o_locked !== 1'b0)    begin errors++; $display("FAIL loss_locked got %b exp 0", o_locked); end
    n = 0;
    while (o_locked !== 1'b1 && n < 300) begin
      prs_bit(bb);
      drive(1'b1, bb);
      n++;
    end
    checks++;
    if (n != 79) begin errors++; $display("FAIL relock_bits got %0d exp 79", n); end
    i_loss_thr = 24'd10;
  endtask

  task automatic test_zero();
    logic seen;
    do_reset();
    seen = 1'b0;
    for (int k = 0; k < 500; k++) begin
      drive(1'b1, 1'b0);
      if (o_locked !== 1'b0) seen = 1'b1;
    end
    checks += 2;
    if (seen !== 1'b0)      begin errors++; $display("FAIL zero_locked got %b exp 0", seen); end
    if (o_bit_total !== '0) begin errors++; $display("FAIL zero_bit_total got %0d exp 0", o_bit_total); end
  endtask

  task automatic test_invert();
    logic bb;
    logic seen;
    do_reset();
    i_invert = 1'b1;
    lock_up(1'b1);
    for (int k = 0; k < 1000; k++) begin
      prs_bit(bb);
      drive(1'b1, ~bb);
    end
    checks += 3;
    if (o_win_vld !== 1'b1) begin errors++; $display("FAIL inv_win_vld got %b exp 1", o_win_vld); end
    if (o_win_err !== '0)   begin errors++; $display("FAIL inv_win_err got %0d exp 0", o_win_err); end
    if (o_err_total !== '0) begin errors++; $display("FAIL inv_err_total got %0d exp 0", o_err_total); end
    do_reset();
    i_invert = 1'b0;
    g = 15'h0001;
    seen = 1'b0;
    for (int k = 0; k < 500; k++) begin
      prs_bit(bb);
      drive(1'b1, ~bb);
      if (o_locked !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL noinv_locked got %b exp 0", seen); end
  endtask

  task automatic test_clear_sparse();
    logic bb;
    logic [TOT_W-1:0] exp_tot;
    do_reset();
    i_window_len = 24'd100;
    i_loss_thr   = 24'd10;
    lock_up(1'b0);
    for (int k = 1; k <= 199; k++) begin
      prs_bit(bb);
      if (k == 51) i_clear = 1'b1;
      drive(1'b1, bb);
      i_clear = 1'b0;
      checks++;
      if (o_win_vld !== (k == 100)) begin errors++; $display("FAIL sparse_win k=%0d got %b exp %b", k, o_win_vld, k == 100); end
      if (k == 100) begin
        checks++;
        if (o_win_err !== '0) begin errors++; $display("FAIL sparse_win_err got %0d exp 0", o_win_err); end
      end
      exp_tot = (k == 50) ? 32'd50 : (k == 51) ? 32'd0 : (k == 150) ? 32'd30 : 32'hFFFF_FFFF;
      if (exp_tot != 32'hFFFF_FFFF) begin
        checks += 2;
        if (o_bit_total !== exp_tot) begin errors++; $display("FAIL sparse_bit_total k=%0d got %0d exp %0d", k, o_bit_total, exp_tot); end
        if (o_locked !== 1'b1)      begin errors++; $display("FAIL sparse_locked k=%0d got %b exp 1", k, o_locked); end
      end
      if (k == 120) begin
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        checks += 2;
        if (o_bit_total !== '0) begin errors++; $display("FAIL idle_clr_bit got %0d exp 0", o_bit_total); end
        if (o_err_total !== '0) begin errors++; $display("FAIL idle_clr_err got %0d exp 0", o_err_total); end
      end
      if (k <= 150) begin
        for (int j = 0; j < 63; j++) tick();
      end
    end
    nRESET = 1'b0;
    prs_bit(bb);
    drive(1'b1, bb);
    checks += 4;
    if (o_win_vld !== 1'b0) begin errors++; $display("FAIL midrst_win_vld got %b exp 0", o_win_vld); end
    if (o_locked !== 1'b0)  begin errors++; $display("FAIL midrst_locked got %b exp 0", o_locked); end
    if (o_bit_total !== '0) begin errors++; $display("FAIL midrst_bit_total got %0d exp 0", o_bit_total); end
    if (o_win_err !== '0)   begin errors++; $display("FAIL midrst_win_err got %0d exp 0", o_win_err); end
    nRESET = 1'b1;
    tick();
    checks++;
    if (o_win_vld !== 1'b0) begin errors++; $display("FAIL postrst_win_vld got %b exp 0", o_win_vld); end
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lock_clean();
    test_errors();
    test_win_shrink();
    test_loss();
    test_zero();
    test_invert();
    test_clear_sparse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
